// File: rtl/switch_debounce_if.sv
// rtl/switch_debounce_if.sv - switch level and conditioned event bundle for switch_debounce
interface switch_debounce_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] switch;
    logic [WIDTH-1:0] sw_clean;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic [WIDTH-1:0] sw_toggle;

    // Board/stimulus side: drives raw levels, consumes conditioned outputs.
    modport master (
        output switch,
        input  sw_clean,
        input  sw_rise,
        input  sw_fall,
        input  sw_toggle
    );

    // Debouncer side.
    modport slave (
        input  switch,
        output sw_clean,
        output sw_rise,
        output sw_fall,
        output sw_toggle
    );
endinterface

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - two-flop synchroniser and per-bit stability-counter debouncer
module switch_debounce #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    switch_debounce_if.slave sw
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_nxt  [WIDTH];
    logic [WIDTH-1:0] clean_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] toggle_q;
    logic [WIDTH-1:0] clean_nxt;
    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;
    logic [WIDTH-1:0] toggle_nxt;

    // Two-stage synchroniser; only sync2 is allowed to reach the debounce logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw.switch;
            sync2 <= sync1;
        end
    end

    // Per-bit stability count: any sample matching the clean level restarts the count,
    // so only an unbroken run of DEBOUNCE_CYCLES mismatched samples is accepted.
    always_comb begin
        cnt_nxt    = cnt;
        clean_nxt  = clean_q;
        rise_nxt   = '0;
        fall_nxt   = '0;
        toggle_nxt = toggle_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] != clean_q[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    cnt_nxt[i]    = '0;
                    clean_nxt[i]  = sync2[i];
                    rise_nxt[i]   = sync2[i];
                    fall_nxt[i]   = ~sync2[i];
                    toggle_nxt[i] = toggle_q[i] ^ sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_ONE;
                end
            end else begin
                cnt_nxt[i] = '0;
            end
        end
    end

    // Register counters and all outputs so no raw input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            clean_q  <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            toggle_q <= '0;
        end else begin
            cnt      <= cnt_nxt;
            clean_q  <= clean_nxt;
            rise_q   <= rise_nxt;
            fall_q   <= fall_nxt;
            toggle_q <= toggle_nxt;
        end
    end

    assign sw.sw_clean  = clean_q;
    assign sw.sw_rise   = rise_q;
    assign sw.sw_fall   = fall_q;
    assign sw.sw_toggle = toggle_q;
endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - directed bench for switch_debounce with DEBOUNCE_CYCLES=4
module tb_switch_debounce;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    switch_debounce_if #(.WIDTH(2)) sw_if ();

    switch_debounce #(
        .WIDTH           (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare {clean, rise, fall, toggle} against the hand-computed values.
    task automatic chk(input string tag, input logic [1:0] e_clean, input logic [1:0] e_rise,
                       input logic [1:0] e_fall, input logic [1:0] e_tog);
        logic [7:0] obs;
        logic [7:0] exp_v;
        obs   = {sw_if.sw_clean, sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_toggle};
        exp_v = {e_clean, e_rise, e_fall, e_tog};
        n_vec++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: clean/rise/fall/toggle observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;

        // Reset held with both switches high: everything stays 0.
        rst_n = 1'b0;
        sw_if.switch = 2'b11;
        tick();
        tick();
        chk("reset_hold", 2'b00, 2'b00, 2'b00, 2'b00);
        rst_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk("rel_wait", 2'b00, 2'b00, 2'b00, 2'b00);
        end
        tick();
        chk("rel_accept", 2'b11, 2'b11, 2'b00, 2'b11);
        tick();
        chk("rel_pulse_end", 2'b11, 2'b00, 2'b00, 2'b11);

        // Drop both to 0: fall pulse, toggle unaffected.
        sw_if.switch = 2'b00;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk("fall_wait", 2'b11, 2'b00, 2'b00, 2'b11);
        end
        tick();
        chk("fall_accept", 2'b00, 2'b00, 2'b11, 2'b11);
        tick();
        chk("fall_end", 2'b00, 2'b00, 2'b00, 2'b11);

        // Clean step on bit 0 held 100 ns.
        sw_if.switch = 2'b01;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk("step_wait", 2'b00, 2'b00, 2'b00, 2'b11);
        end
        tick();
        chk("step_accept", 2'b01, 2'b01, 2'b00, 2'b10);
        for (int e = 7; e <= 10; e++) begin
            tick();
            chk("step_hold", 2'b01, 2'b00, 2'b00, 2'b10);
        end

        // Bounce on bit 1 every 20 ns, never stable long enough.
        for (int b = 0; b < 4; b++) begin
            sw_if.switch = (b % 2 == 0) ? 2'b11 : 2'b01;
            tick();
            chk("bounce", 2'b01, 2'b00, 2'b00, 2'b10);
            tick();
            chk("bounce", 2'b01, 2'b00, 2'b00, 2'b10);
        end
        sw_if.switch = 2'b11;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk("bounce_settle", 2'b01, 2'b00, 2'b00, 2'b10);
        end
        tick();
        chk("bounce_accept", 2'b11, 2'b10, 2'b00, 2'b00);
        tick();
        chk("bounce_end", 2'b11, 2'b00, 2'b00, 2'b00);

        // Bring bit 0 back to 0 before the glitch test.
        sw_if.switch = 2'b10;
        for (int e = 1; e <= 5; e++) tick();
        tick();
        chk("b0_fall", 2'b10, 2'b00, 2'b01, 2'b00);
        tick();

        // 30 ns glitch on bit 0: three samples, one short of acceptance.
        sw_if.switch = 2'b11;
        tick();
        tick();
        tick();
        sw_if.switch = 2'b10;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("glitch", 2'b10, 2'b00, 2'b00, 2'b00);
        end

        // Three press/release cycles on bit 0, each level held 80 ns.
        for (int p = 1; p <= 3; p++) begin
            logic [1:0] tg;
            tg = (p % 2 == 1) ? 2'b01 : 2'b00;
            sw_if.switch = 2'b11;
            for (int e = 1; e <= 8; e++) begin
                tick();
                if (e < 6) chk("press_wait", 2'b10, 2'b00, 2'b00, tg ^ 2'b01);
                else if (e == 6) chk("press_rise", 2'b11, 2'b01, 2'b00, tg);
                else chk("press_hold", 2'b11, 2'b00, 2'b00, tg);
            end
            sw_if.switch = 2'b10;
            for (int e = 1; e <= 8; e++) begin
                tick();
                if (e < 6) chk("rel_wait0", 2'b11, 2'b00, 2'b00, tg);
                else if (e == 6) chk("rel_fall", 2'b10, 2'b00, 2'b01, tg);
                else chk("rel_hold", 2'b10, 2'b00, 2'b00, tg);
            end
        end

        // Reset mid-count on bit 0, input kept high through release.
        sw_if.switch = 2'b11;
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk("pre_rst_count", 2'b10, 2'b00, 2'b00, 2'b01);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 2'b00, 2'b00, 2'b00, 2'b00);
        tick();
        chk("rst_held", 2'b00, 2'b00, 2'b00, 2'b00);
        rst_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk("rst2_wait", 2'b00, 2'b00, 2'b00, 2'b00);
        end
        tick();
        chk("rst2_accept", 2'b11, 2'b11, 2'b00, 2'b11);
        tick();
        chk("rst2_end", 2'b11, 2'b00, 2'b00, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Input conditioner between board slide switches/buttons and the logic-gate and LED blocks.
- Synchronises each raw switch bit to `clk` and debounces it with a per-bit stability counter.
- Outputs the clean level plus single-cycle rise/fall pulses and a per-bit toggle state.
- The clean outputs feed the `switch` inputs of downstream gate blocks, replacing direct use of raw pins.

Parameters:
- WIDTH, 2, number of independent switch bits conditioned.
- DEBOUNCE_CYCLES, 20, consecutive clocks a new synchronised level must persist before acceptance; must be >= 1. Use 20 for simulation and about 1_000_000 for a 100 MHz board (10 ms).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width (derived; do not override).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion clears all state immediately, release synchronous to clk.
- switch  input  WIDTH  raw asynchronous switch/button levels.
- sw_clean  output  WIDTH  debounced level per bit.
- sw_rise  output  WIDTH  one-clock pulse when sw_clean bit goes 0->1.
- sw_fall  output  WIDTH  one-clock pulse when sw_clean bit goes 1->0.
- sw_toggle  output  WIDTH  per-bit state that inverts on each sw_rise of that bit.

Behaviour:
- Reset (rst_n=0, asynchronous): both sync stages, all counters, sw_clean, sw_rise, sw_fall and sw_toggle go to 0.
- Synchroniser: two flops per bit, sync1 <= switch and sync2 <= sync1. Only sync2 is used downstream.
- Per-bit debounce, each bit independent:
  - Mismatch is sync2 != sw_clean.
  - Mismatch and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - Mismatch and cnt == DEBOUNCE_CYCLES-1: sw_clean <= sync2, cnt <= 0, and the matching pulse (rise if sync2=1, fall if 0) is asserted for that one cycle.
  - No mismatch: cnt <= 0 (glitch rejection; any return to the clean level restarts the count).
- Latency: sw_clean changes on the (DEBOUNCE_CYCLES+2)th rising edge, counting the edge that first samples the new raw level as edge 1. sw_rise/sw_fall are high exactly in the cycle after that edge, coincident with the new sw_clean.
- Pulses:
  - sw_rise and sw_fall are registered and high for exactly one clock.
  - They are never both high on the same bit.
  - Different bits may pulse in the same cycle.
- sw_toggle: bit i inverts on the same edge sw_rise[i] is set; fall events do not affect it.
- DEBOUNCE_CYCLES=1: accepted after one mismatched edge after sync, giving 3-edge latency.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around possible.
- Bouncing input: each toggle that returns to the clean level before acceptance clears the count. Only a level held DEBOUNCE_CYCLES consecutive sync2 samples is accepted.
- Reset mid-count: count discarded and sw_clean=0. If the switch is held high through reset release, sw_rise fires DEBOUNCE_CYCLES+2 edges after release.
- No combinational path from switch to any output.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=2, clk period 10 ns):
- Reset while switch=2'b11 → all outputs 0 during reset. After release, sw_clean=2'b11 after 6 edges, with a single-cycle sw_rise=2'b11 and sw_toggle=2'b11.
- Clean step switch[0] 0->1 held 100 ns → sw_clean[0] rises on the 6th edge. sw_rise[0] high exactly 1 cycle, sw_fall stays 0, sw_clean[1] unchanged.
- Bounce switch[1] 1-0-1-0 every 20 ns (pulses shorter than 4 sync samples), then hold 1 → no event during bounce. One sw_rise[1] occurs 6 edges after the final stable 1.
- Glitch: switch[0]=1 for 30 ns from clean 0 → sw_clean[0] stays 0, no pulses.
- Press/release switch[0] three times, each level held 80 ns → three sw_rise and three sw_fall pulses; sw_toggle[0] sequence 1,0,1.
- Assert rst_n=0 mid-count (2 edges into a 0->1 mismatch), release with input still 1 → outputs 0 immediately on assertion. sw_rise fires 6 edges after release.
